// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus layout, FSM states
// and the default exception entry point.
package pipeline_ctrl_pkg;

  // Width of the per-stage hold bus.
  localparam int unsigned StallBus = 6;

  // Bit positions on the stall bus, fetch side first.
  localparam int unsigned StallPc   = 0;
  localparam int unsigned StallIfId = 1;
  localparam int unsigned StallIdEx = 2;
  localparam int unsigned StallExMem = 3;
  localparam int unsigned StallMemWb = 4;
  localparam int unsigned StallWb   = 5;

  localparam logic [31:0] DefaultExcVector = 32'hBFC00380;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StWaitIf = 2'd1,
    StFlush  = 2'd2
  } ctrl_state_e;

  // Hold mask covering every stage from the PC up to and including bit idx.
  function automatic logic [StallBus-1:0] stall_through(input int unsigned idx);
    logic [StallBus-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < StallBus; i++) begin
      if (i <= idx) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: priority-encodes per-stage stall
// requests and turns a committed exception or ERET into a single-cycle flush
// with a redirect PC, waiting for any in-flight fetch to finish first.
// Optional performance counters are built when PIPELINE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DefaultExcVector
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                exc_valid,
  input  logic                exc_is_eret,
  input  logic [31:0]         cp0_epc,
  output logic [StallBus-1:0] stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
);

  ctrl_state_e state_q, state_d;
  logic [31:0] target_q, target_d;

  // State and redirect-target registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Next state, target capture and stall/flush/new_pc decode.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    stall    = '0;
    flush    = 1'b0;
    new_pc   = 32'h0;

    unique case (state_q)
      StRun: begin
        if (stallreq_mem)     stall = stall_through(StallMemWb);
        else if (stallreq_ex) stall = stall_through(StallExMem);
        else if (stallreq_id) stall = stall_through(StallIdEx);
        else if (stallreq_if) stall = stall_through(StallIfId);

        if (exc_valid) begin
          target_d = exc_is_eret ? cp0_epc : EXC_VECTOR;
          // An outstanding fetch must drain before the redirect takes effect.
          state_d  = stallreq_if ? StWaitIf : StFlush;
        end
      end
      StWaitIf: begin
        // Freeze everything; later exceptions belong to squashed instructions.
        stall = stall_through(StallWb);
        if (!stallreq_if) state_d = StFlush;
      end
      StFlush: begin
        flush   = 1'b1;
        new_pc  = target_q;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 32'h0;
    end else begin
      if (stall != '0) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush)       flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each step drives one cycle of inputs,
// pushes the reference prediction, then pops and compares it against the DUT.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam int MdlRun   = 0;
  localparam int MdlWait  = 1;
  localparam int MdlFlush = 2;
  localparam logic [31:0] ExcVec = 32'hBFC00380;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        exc_valid, exc_is_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles, flush_count;

  int n_vec = 0;
  int n_bad = 0;

  int          m_state;
  logic [31:0] m_tgt;
  logic [31:0] m_sc, m_fc;
  exp_t        sb[$];

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .exc_valid    (exc_valid),
    .exc_is_eret  (exc_is_eret),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference prediction for the current cycle; req = {mem, ex, id, if}.
  function automatic exp_t predict(input logic [3:0] req);
    exp_t e;
    e.stall  = 6'b000000;
    e.flush  = 1'b0;
    e.new_pc = 32'h0;
    if (m_state == MdlFlush) begin
      e.flush  = 1'b1;
      e.new_pc = m_tgt;
    end else if (m_state == MdlWait) begin
      e.stall = 6'b111111;
    end else begin
      casez (req)
        4'b1???: e.stall = 6'b011111;
        4'b01??: e.stall = 6'b001111;
        4'b001?: e.stall = 6'b000111;
        4'b0001: e.stall = 6'b000011;
        default: e.stall = 6'b000000;
      endcase
    end
    e.sc = PerfEn ? m_sc : 32'h0;
    e.fc = PerfEn ? m_fc : 32'h0;
    return e;
  endfunction

  task automatic step(input string tag, input logic [3:0] req, input logic ev,
                      input logic er, input logic [31:0] epc, input logic rst);
    exp_t e, o;
    @(negedge clk);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    exc_valid   = ev;
    exc_is_eret = er;
    cp0_epc     = epc;
    reset       = rst;
    e = predict(req);
    sb.push_back(e);
    #2;
    o = sb.pop_front();
    check_val({tag, ".stall"}, {26'h0, stall}, {26'h0, o.stall});
    check_val({tag, ".flush"}, {31'h0, flush}, {31'h0, o.flush});
    check_val({tag, ".new_pc"}, new_pc, o.new_pc);
    check_val({tag, ".stall_cycles"}, stall_cycles, o.sc);
    check_val({tag, ".flush_count"}, flush_count, o.fc);
    @(posedge clk);
    if (rst) begin
      m_state = MdlRun;
      m_tgt   = 32'h0;
      m_sc    = 32'h0;
      m_fc    = 32'h0;
    end else begin
      if (e.stall != 6'b0) m_sc = m_sc + 32'd1;
      if (e.flush) m_fc = m_fc + 32'd1;
      case (m_state)
        MdlRun: if (ev) begin
          m_tgt   = er ? epc : ExcVec;
          m_state = req[0] ? MdlWait : MdlFlush;
        end
        MdlWait: if (!req[0]) m_state = MdlFlush;
        default: m_state = MdlRun;
      endcase
    end
  endtask

  initial begin
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0;
    exc_valid = 1'b0; exc_is_eret = 1'b0; cp0_epc = 32'h0; reset = 1'b1;
    m_state = MdlRun; m_tgt = 32'h0; m_sc = 32'h0; m_fc = 32'h0;
    @(posedge clk);

    // Reset state and stall priority encoding.
    step("rst_idle", 4'b0000, 0, 0, 32'h0, 0);
    step("id_only",  4'b0010, 0, 0, 32'h0, 0);
    step("mem_id",   4'b1010, 0, 0, 32'h0, 0);
    step("if_only",  4'b0001, 0, 0, 32'h0, 0);
    step("ex_if",    4'b0101, 0, 0, 32'h0, 0);
    step("all_req",  4'b1111, 0, 0, 32'h0, 0);

    // Exception with idle fetch: flush next cycle to the vector.
    step("exc",      4'b0000, 1, 0, 32'h0, 0);
    step("exc_fl",   4'b0000, 0, 0, 32'h0, 0);
    step("exc_done", 4'b0000, 0, 0, 32'h0, 0);

    // ERET behind a busy fetch: three frozen cycles, then one flush.
    step("eret",     4'b0001, 1, 1, 32'h80001234, 0);
    step("eret_w1",  4'b1001, 0, 0, 32'h0, 0);
    step("eret_w2",  4'b0001, 0, 0, 32'h0, 0);
    step("eret_w3",  4'b0000, 0, 0, 32'h0, 0);
    step("eret_fl",  4'b0000, 0, 0, 32'h0, 0);
    step("eret_end", 4'b0000, 0, 0, 32'h0, 0);

    // Second exception while waiting is dropped; flush cycle overrides requests.
    step("dup_a",    4'b0001, 1, 1, 32'h11112220, 0);
    step("dup_b",    4'b0001, 1, 1, 32'h33334440, 0);
    step("dup_c",    4'b0000, 1, 0, 32'h0, 0);
    step("dup_fl",   4'b1111, 1, 1, 32'h55556660, 0);
    step("dup_end",  4'b0000, 0, 0, 32'h0, 0);

    // Reset while waiting abandons the redirect.
    step("rw_exc",   4'b0001, 1, 0, 32'h0, 0);
    step("rw_wait",  4'b0001, 0, 0, 32'h0, 0);
    step("rw_rst",   4'b0000, 0, 0, 32'h0, 1);
    step("rw_a",     4'b0000, 0, 0, 32'h0, 0);
    step("rw_b",     4'b0000, 0, 0, 32'h0, 0);

    // Reset landing on the flush cycle.
    step("rf_exc",   4'b0000, 1, 1, 32'hA0000040, 0);
    step("rf_rst",   4'b0000, 0, 0, 32'h0, 1);
    step("rf_a",     4'b0000, 0, 0, 32'h0, 0);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      step("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0), 1'($urandom),
           $urandom, ($urandom_range(0, 40) == 0));
    end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    step("pc_rst", 4'b0000, 0, 0, 32'h0, 1);
    for (int i = 0; i < 5; i++) step("pc_st", 4'b0100, 0, 0, 32'h0, 0);
    step("pc_exc", 4'b0000, 1, 0, 32'h0, 0);
    step("pc_fl",  4'b0000, 0, 0, 32'h0, 0);
    step("pc_chk", 4'b0000, 0, 0, 32'h0, 0);
    check_val("perf_stall5", stall_cycles, 32'd5);
    check_val("perf_flush1", flush_count, 32'd1);
    @(negedge clk);
    dut.stall_cycles_q = 32'hFFFFFFFF;
    m_sc = 32'hFFFFFFFF;
    step("pc_max",  4'b0010, 0, 0, 32'h0, 0);
    step("pc_wrap", 4'b0000, 0, 0, 32'h0, 0);
    check_val("perf_wrap", stall_cycles, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380: exception handler entry PC.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port stallreq_if, input, 1: fetch not complete (instruction bus busy).
REQ-005 SHALL have port stallreq_id, input, 1: load-use hazard.
REQ-006 SHALL have port stallreq_ex, input, 1: multi-cycle EX op (mul/div) busy.
REQ-007 SHALL have port stallreq_mem, input, 1: data access not complete.
REQ-008 SHALL have port exc_valid, input, 1: MEM stage commits an exception/ERET this cycle.
REQ-009 SHALL have port exc_is_eret, input, 1: qualifies exc_valid as ERET.
REQ-010 SHALL have port cp0_epc, input, 32: EPC for ERET.
REQ-011 SHALL have port stall, output, 6 (`StallBus): hold per stage, bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-012 SHALL have port flush, output, 1: clear all pipeline registers.
REQ-013 SHALL have port new_pc, output, 32: redirect target, valid while flush=1.
REQ-014 SHALL have ports stall_cycles and flush_count, output, 32 each: performance counters.

Function
REQ-015 SHALL compute stall combinationally by priority mem > ex > id > if: 6'b011111, 6'b001111, 6'b000111, 6'b000011; none -> 6'b000000.
REQ-016 SHALL use FSM states RUN, WAIT_IF, FLUSH, encoded in a 2-bit register.
REQ-017 SHALL in RUN, on exc_valid with stallreq_if=0, go to FLUSH; with stallreq_if=1, go to WAIT_IF.
REQ-018 SHALL latch the target on exc_valid acceptance: cp0_epc if exc_is_eret, else EXC_VECTOR.
REQ-019 SHALL in WAIT_IF drive stall=6'b111111 and flush=0, holding until stallreq_if=0, then go to FLUSH.
REQ-020 SHALL in FLUSH drive flush=1, stall=6'b000000 and new_pc=latched target for exactly one cycle, then return to RUN.
REQ-021 SHALL ignore exc_valid in WAIT_IF and FLUSH, because the pending redirect supersedes younger instructions.
REQ-022 SHALL drive new_pc=32'h0 whenever flush=0.
REQ-023 SHALL give flush priority over stall: when flush=1, stall=0 regardless of requests.
REQ-024 SHALL count latency from exc_valid to flush as 1 cycle in RUN with fetch idle, and 1+N cycles with N further cycles of stallreq_if.

Reset
REQ-025 SHALL on reset=1 at a clock edge set state=RUN, latched target=0 and counters=0; stall, flush and new_pc outputs become 0 from that edge.
REQ-026 SHALL abandon any pending WAIT_IF/FLUSH on a reset mid-operation, with no flush pulse issued.

Configuration
REQ-027 SHALL, when macro PIPELINE_CTRL_PERF_CNT_EN is defined, increment stall_cycles on every cycle with stall!=0 and flush_count on every cycle with flush=1, both 32-bit wrapping 32'hFFFFFFFF -> 0.
REQ-028 SHALL, when PIPELINE_CTRL_PERF_CNT_EN is undefined, tie stall_cycles and flush_count to 0 and synthesize no counter registers.

Structure
REQ-029 SHALL take `StallBus, the stall bit indices, FSM state constants and the default exception vector from the shared defines package.
REQ-030 SHALL be a single module; stall priority encoding stays inline, with no sub-module.

Verification
REQ-031 SHALL cover: stallreq_id=1 only -> stall=6'b000111; plus stallreq_mem=1 -> stall=6'b011111.
REQ-032 SHALL cover: exc_valid=1, exc_is_eret=0, stallreq_if=0 -> next cycle flush=1, new_pc=32'hBFC00380, then flush=0.
REQ-033 SHALL cover: exc_valid=1, exc_is_eret=1, cp0_epc=32'h80001234, stallreq_if=1 for 3 cycles -> stall=6'b111111 for 3 cycles, then one cycle of flush=1 with new_pc=32'h80001234.
REQ-034 SHALL cover: a second exc_valid during WAIT_IF -> ignored, exactly one flush pulse with the first target.
REQ-035 SHALL cover: reset asserted in WAIT_IF -> next cycle state RUN, flush=0, stall=0, no later flush pulse.
REQ-036 SHALL cover, with PIPELINE_CTRL_PERF_CNT_EN: 5 stalled cycles plus 1 flush -> stall_cycles=5, flush_count=1; preloading stall_cycles to 32'hFFFFFFFF and stalling once -> 0.
